// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches one opcode byte per instruction, decodes it and
// drives the ALU/register block control lines for exactly one execute cycle.
// Supports free-run (run=1) and single-step (run=0, one fetch per step pulse).
//
// Handshake: ir_req is registered and is the sequencer's "ready" for an opcode;
// ir_valid is the source's "valid". A byte is consumed only on a rising edge
// where ir_req and ir_valid are both high. ir_valid high while ir_req is low
// consumes nothing and the source must hold the byte.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] ir_in,
    input  logic       ir_valid,
    output logic       ir_req,
    output logic       pc_inc,
    input  logic [3:0] fout,
    output logic [3:0] outctl,
    output logic [3:0] loadctl,
    output logic [1:0] arg_l,
    output logic [2:0] arg_r,
    output logic       alt,
    output logic       calcfn,
    output logic       cin,
    output logic       halted,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       arm_q, arm_d;
    logic       ir_req_q, ir_req_d;
    logic       pc_inc_q, pc_inc_d;
    logic       halted_q, halted_d;
    logic [3:0] outctl_q, outctl_d;
    logic [3:0] loadctl_q, loadctl_d;
    logic [1:0] arg_l_q, arg_l_d;
    logic [2:0] arg_r_q, arg_r_d;
    logic       alt_q, alt_d;
    logic       calcfn_q, calcfn_d;
    logic       cin_q, cin_d;

    // Decoded control word for the byte currently on ir_in
    logic [3:0] dec_outctl, dec_loadctl;
    logic [1:0] dec_arg_l;
    logic [2:0] dec_arg_r;
    logic       dec_alt, dec_calcfn, dec_cin;

    logic [2:0] op;
    logic       cbit;
    logic [1:0] dfld, sfld;
    logic       carry;
    logic       accept;
    logic       ir_is_hlt;

    // Only the carry flag feeds the sequencer; Z/V/N belong to other consumers.
    logic       unused_flags;
    assign unused_flags = &{1'b0, fout[3:1]};

    assign op     = ir_in[7:5];
    assign cbit   = ir_in[4];
    assign dfld   = ir_in[3:2];
    assign sfld   = ir_in[1:0];
    assign carry  = fout[0];
    assign accept = (state_q == S_FETCH) && ir_req_q && ir_valid;
    assign ir_is_hlt = (ir_q[7:4] == 4'hF) && (ir_q[1:0] == 2'b11);

    // Opcode decode into the control word (idle unless a defined op matches)
    always_comb begin
        dec_outctl  = 4'hF;
        dec_loadctl = 4'hF;
        dec_arg_l   = 2'd0;
        dec_arg_r   = 3'h7;
        dec_alt     = 1'b0;
        dec_calcfn  = 1'b1;
        dec_cin     = 1'b0;
        if (op != 3'b111) begin
            dec_arg_l   = dfld;
            dec_arg_r   = {1'b0, sfld};
            dec_loadctl = {2'b00, dfld};
            dec_calcfn  = 1'b0;
            case (op)
                3'b000: begin dec_outctl = 4'h5; dec_cin = cbit & carry; end
                3'b001: begin dec_outctl = 4'h5; dec_alt = 1'b1; dec_cin = cbit ? carry : 1'b1; end
                3'b010: dec_outctl = 4'h6;
                3'b011: begin dec_outctl = 4'h6; dec_alt = 1'b1; end
                3'b100: dec_outctl = 4'hA;
                3'b101: begin dec_outctl = 4'hA; dec_alt = 1'b1; end
                default: begin
                    dec_outctl = 4'h7;
                    dec_alt    = cbit;
                    dec_arg_r  = 3'h7;
                    dec_cin    = sfld[0] & carry;
                end
            endcase
        end else if (!cbit) begin
            dec_outctl  = {2'b00, sfld};
            dec_loadctl = {2'b00, dfld};
        end else if (sfld == 2'b00) begin
            dec_arg_l   = dfld;
            dec_arg_r   = 3'h6;
            dec_outctl  = 4'h5;
            dec_loadctl = {2'b00, dfld};
            dec_calcfn  = 1'b0;
        end
    end

    // Next state, step arming and registered output values
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        arm_d     = arm_q;
        ir_req_d  = 1'b0;
        pc_inc_d  = 1'b0;
        halted_d  = halted_q;
        outctl_d  = 4'hF;
        loadctl_d = 4'hF;
        arg_l_d   = 2'd0;
        arg_r_d   = 3'h7;
        alt_d     = 1'b0;
        calcfn_d  = 1'b1;
        cin_d     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    state_d   = S_EXEC;
                    ir_d      = ir_in;
                    pc_inc_d  = 1'b1;
                    // A step arriving on the accepting edge stays pending
                    arm_d     = step;
                    outctl_d  = dec_outctl;
                    loadctl_d = dec_loadctl;
                    arg_l_d   = dec_arg_l;
                    arg_r_d   = dec_arg_r;
                    alt_d     = dec_alt;
                    calcfn_d  = dec_calcfn;
                    cin_d     = dec_cin;
                end else begin
                    arm_d    = arm_q | step;
                    ir_req_d = run | arm_d;
                end
            end
            S_EXEC: begin
                if (ir_is_hlt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    arm_d    = 1'b0;
                end else begin
                    state_d  = S_FETCH;
                    arm_d    = arm_q | step;
                    ir_req_d = run | arm_d;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
                arm_d    = 1'b0;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and output registers, asynchronously cleared to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 8'h00;
            arm_q     <= 1'b0;
            ir_req_q  <= 1'b0;
            pc_inc_q  <= 1'b0;
            halted_q  <= 1'b0;
            outctl_q  <= 4'hF;
            loadctl_q <= 4'hF;
            arg_l_q   <= 2'd0;
            arg_r_q   <= 3'h7;
            alt_q     <= 1'b0;
            calcfn_q  <= 1'b1;
            cin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            arm_q     <= arm_d;
            ir_req_q  <= ir_req_d;
            pc_inc_q  <= pc_inc_d;
            halted_q  <= halted_d;
            outctl_q  <= outctl_d;
            loadctl_q <= loadctl_d;
            arg_l_q   <= arg_l_d;
            arg_r_q   <= arg_r_d;
            alt_q     <= alt_d;
            calcfn_q  <= calcfn_d;
            cin_q     <= cin_d;
        end
    end

    assign ir_req    = ir_req_q;
    assign pc_inc    = pc_inc_q;
    assign halted    = halted_q;
    assign outctl    = outctl_q;
    assign loadctl   = loadctl_q;
    assign arg_l     = arg_l_q;
    assign arg_r     = arg_r_q;
    assign alt       = alt_q;
    assign calcfn    = calcfn_q;
    assign cin       = cin_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed instruction checks plus a randomized
// run/step/valid stream compared against a behavioural model.
module tb_alu_sequencer;

    localparam logic [15:0] IDLE_CTL = {4'hF, 4'hF, 2'd0, 3'h7, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [7:0] ir_in = 8'h00;
    logic       ir_valid = 1'b0;
    logic [3:0] fout = 4'h0;
    logic       ir_req, pc_inc, alt, calcfn, cin, halted;
    logic [3:0] outctl, loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic [1:0] unused_dbg_state;
    logic [15:0] dut_ctl;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int obs_pc = 0;

    // behavioural model state
    logic m_req = 1'b0, m_exec = 1'b0, m_halted = 1'b0, m_pend = 1'b0, m_last_hlt = 1'b0;
    logic [15:0] exp_q[$];

    alu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .ir_in(ir_in),
        .ir_valid(ir_valid), .ir_req(ir_req), .pc_inc(pc_inc), .fout(fout),
        .outctl(outctl), .loadctl(loadctl), .arg_l(arg_l), .arg_r(arg_r),
        .alt(alt), .calcfn(calcfn), .cin(cin), .halted(halted),
        .dbg_state(unused_dbg_state)
    );

    assign dut_ctl = {outctl, loadctl, arg_l, arg_r, alt, calcfn, cin};

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_hlt(input logic [7:0] b);
        return (b[7:4] == 4'hF) && (b[1:0] == 2'b11);
    endfunction

    // Control word per instruction table: {outctl, loadctl, arg_l, arg_r, alt, calcfn, cin}
    function automatic logic [15:0] ref_ctl(input logic [7:0] b, input logic c_flag);
        int op, cb, d, s, o, l, al, ar, al_t, cf, ci;
        op = int'(b[7:5]); cb = int'(b[4]); d = int'(b[3:2]); s = int'(b[1:0]);
        o = 15; l = 15; al = 0; ar = 7; al_t = 0; cf = 1; ci = 0;
        if (op < 7) begin
            al = d; l = d; ar = s; cf = 0;
            case (op)
                0: begin o = 5; ci = (cb == 1) ? int'(c_flag) : 0; end
                1: begin o = 5; al_t = 1; ci = (cb == 1) ? int'(c_flag) : 1; end
                2: o = 6;
                3: begin o = 6; al_t = 1; end
                4: o = 10;
                5: begin o = 10; al_t = 1; end
                default: begin o = 7; al_t = cb; ar = 7; ci = (s % 2 == 1) ? int'(c_flag) : 0; end
            endcase
        end else if (cb == 0) begin
            o = s; l = d;
        end else if (s == 0) begin
            al = d; ar = 6; o = 5; l = d; cf = 0;
        end
        return {o[3:0], l[3:0], al[1:0], ar[2:0], al_t[0], cf[0], ci[0]};
    endfunction

    function automatic logic [7:0] rand_op();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (is_hlt(b)) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    task automatic model_reset();
        m_req = 1'b0; m_exec = 1'b0; m_halted = 1'b0; m_pend = 1'b0; m_last_hlt = 1'b0;
        exp_q.delete();
    endtask

    // One clock: update model on the rising edge, compare on the falling edge
    task automatic tick();
        logic [15:0] exp_ctl;
        logic acc;
        @(posedge clk);
        cyc++;
        acc = m_req && ir_valid;
        if (m_halted) begin
            m_req = 1'b0; m_exec = 1'b0;
        end else if (m_exec) begin
            m_exec = 1'b0;
            if (step) m_pend = 1'b1;
            if (m_last_hlt) begin
                m_halted = 1'b1; m_req = 1'b0; m_pend = 1'b0;
            end else begin
                m_req = run || m_pend;
            end
        end else if (acc) begin
            m_exec = 1'b1; m_req = 1'b0; m_pend = step;
            exp_q.push_back(ref_ctl(ir_in, fout[0]));
            m_last_hlt = is_hlt(ir_in);
        end else begin
            if (step) m_pend = 1'b1;
            m_req = run || m_pend;
        end
        @(negedge clk);
        if (pc_inc === 1'b1) obs_pc++;
        chk("ir_req", ir_req, m_req);
        chk("pc_inc", pc_inc, m_exec);
        chk("halted", halted, m_halted);
        if (m_exec) exp_ctl = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        else exp_ctl = IDLE_CTL;
        chk("ctl", dut_ctl, exp_ctl);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, dut_ctl, IDLE_CTL);
        chk({tag, "_req"}, ir_req, 0);
        chk({tag, "_pc"}, pc_inc, 0);
        chk({tag, "_halt"}, halted, 0);
    endtask

    // Present a byte until it is executing (returns on the EXEC cycle)
    task automatic issue(input logic [7:0] b, input logic [3:0] f);
        ir_in = b; fout = f; ir_valid = 1'b1; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_exec) break;
        end
        chk("issue_wait", m_exec, 1);
    endtask

    initial begin
        int c1;
        // reset block
        #2 rst = 1'b0;
        #1 check_reset_vals("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ADD B,C
        run = 1'b1; ir_valid = 1'b1; ir_in = 8'h06; fout = 4'h0;
        tick();
        chk("first_req", ir_req, 1);
        tick();
        chk("add_outctl", outctl, 4'h5);
        chk("add_loadctl", loadctl, 4'h1);
        chk("add_arg_l", arg_l, 2'd1);
        chk("add_arg_r", arg_r, 3'd2);
        chk("add_calcfn", calcfn, 0);
        ir_valid = 1'b0;
        tick();
        chk("add_after_req", ir_req, 1);
        chk("add_after_outctl", outctl, 4'hF);

        // carry-chained sub and plain sub
        issue(8'h33, 4'b0001);
        chk("sbc_c1_cin", cin, 1);
        chk("sbc_c1_alt", alt, 1);
        issue(8'h33, 4'b0000);
        chk("sbc_c0_cin", cin, 0);
        issue(8'h23, 4'b0000);
        chk("sub_cin", cin, 1);

        // MOV then CLR back-to-back
        issue(8'hE6, 4'h0);
        c1 = cyc;
        chk("mov_outctl", outctl, 4'h2);
        chk("mov_loadctl", loadctl, 4'h1);
        chk("mov_arg_r", arg_r, 3'h7);
        chk("mov_calcfn", calcfn, 1);
        issue(8'hF4, 4'h0);
        chk("clr_gap", cyc - c1, 2);
        chk("clr_arg_r", arg_r, 3'h6);
        chk("clr_outctl", outctl, 4'h5);
        chk("clr_loadctl", loadctl, 4'h1);
        chk("clr_calcfn", calcfn, 0);

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            run = ($urandom_range(0, 3) != 0);
            step = ($urandom_range(0, 7) == 0);
            ir_valid = ($urandom_range(0, 3) != 0);
            ir_in = rand_op();
            fout = 4'($urandom_range(0, 15));
            tick();
        end
        step = 1'b0;

        // reset in the middle of EXEC
        issue(8'h06, 4'h0);
        rst = 1'b0;
        #1;
        chk("rst_exec_outctl", outctl, 4'hF);
        chk("rst_exec_loadctl", loadctl, 4'hF);
        chk("rst_exec_calcfn", calcfn, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // single-step
        run = 1'b0; ir_valid = 1'b1; ir_in = rand_op(); obs_pc = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("step_no_fetch", obs_pc, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_exec) break;
        end
        chk("step_exec_wait", m_exec, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("step_fetches", obs_pc, 2);

        // halt
        run = 1'b1; ir_valid = 1'b1; ir_in = 8'hF3;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_halted) break;
        end
        chk("halt_reached", halted, 1);
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            ir_in = rand_op();
            tick();
        end
        step = 1'b0;
        rst = 1'b0;
        #1 check_reset_vals("post_halt");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        tick();
        chk("exp_q_empty", exp_q.size(), 0);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
